// File: rtl/difftest_pkg.sv
// Shared definitions for the CSR-state difftest channel: CSR ordering, the
// header layout and the snapshot record that the receiver reconstructs.
package difftest_pkg;

    localparam int NUM_CSR = 18;
    localparam int CSR_W   = 64;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hC5;

    // Header beat layout: {magic, coreid, seq, csr count, dropped}
    localparam int HDR_MAGIC_LSB  = 56;
    localparam int HDR_COREID_LSB = 48;
    localparam int HDR_SEQ_LSB    = 32;
    localparam int HDR_COUNT_LSB  = 24;
    localparam int HDR_DROP_LSB   = 0;
    localparam int HDR_DROP_W     = 24;

    typedef enum logic [4:0] {
        CSR_PRIVILEGE_MODE = 5'd0,
        CSR_MSTATUS        = 5'd1,
        CSR_SSTATUS        = 5'd2,
        CSR_MEPC           = 5'd3,
        CSR_SEPC           = 5'd4,
        CSR_MTVAL          = 5'd5,
        CSR_STVAL          = 5'd6,
        CSR_MTVEC          = 5'd7,
        CSR_STVEC          = 5'd8,
        CSR_MCAUSE         = 5'd9,
        CSR_SCAUSE         = 5'd10,
        CSR_SATP           = 5'd11,
        CSR_MIP            = 5'd12,
        CSR_MIE            = 5'd13,
        CSR_MSCRATCH       = 5'd14,
        CSR_SSCRATCH       = 5'd15,
        CSR_MIDELEG        = 5'd16,
        CSR_MEDELEG        = 5'd17
    } csr_idx_e;

    typedef struct packed {
        logic [7:0]                        coreid;
        logic [NUM_CSR-1:0][CSR_W-1:0]     csr;
    } csr_snapshot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } ser_state_e;

endpackage

// File: rtl/difftest_csr_serializer.sv
// Captures one CSR snapshot per commit and emits it as a 19-beat 64-bit
// record (header + 18 CSR words) on a valid/ready stream.
module difftest_csr_serializer
    import difftest_pkg::*;
#(
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT,
    parameter int         DROP_W = 16            // at most HDR_DROP_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_coreid,
    input  logic [NUM_CSR-1:0][CSR_W-1:0]  in_csr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [63:0]                    out_data,
    output logic                           out_last,
    output logic [DROP_W-1:0]              dropped
);

    localparam logic [4:0] LAST_BEAT = 5'(CSR_MEDELEG);

    ser_state_e          state, state_nxt;
    logic [4:0]          beat, beat_nxt;
    logic [15:0]         seq;
    logic [DROP_W-1:0]   drop_cnt;
    logic [DROP_W-1:0]   hdr_drop;
    csr_snapshot_t       hold;
    logic                capture;
    logic                seq_inc;
    logic [63:0]         header;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    always_comb begin
        header = '0;
        header[HDR_MAGIC_LSB  +: 8]          = MAGIC;
        header[HDR_COREID_LSB +: 8]          = hold.coreid;
        header[HDR_SEQ_LSB    +: 16]         = seq;
        header[HDR_COUNT_LSB  +: 8]          = 8'(NUM_CSR);
        header[HDR_DROP_LSB   +: HDR_DROP_W] = HDR_DROP_W'(hdr_drop);
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        capture   = 1'b0;
        seq_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = header;
                if (out_ready) begin
                    state_nxt = ST_DATA;
                    beat_nxt  = '0;
                end
            end
            ST_DATA: begin
                out_valid = 1'b1;
                out_data  = hold.csr[beat];
                out_last  = (beat == LAST_BEAT);
                // The next snapshot may land on the last-beat handshake so
                // back-to-back records leave no idle cycle on the link.
                if (beat == LAST_BEAT) in_ready = out_ready;
                if (out_ready) begin
                    if (beat == LAST_BEAT) begin
                        seq_inc = 1'b1;
                        if (in_valid) begin
                            capture   = 1'b1;
                            state_nxt = ST_HDR;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        beat_nxt = beat + 5'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            beat     <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            hdr_drop <= '0;
            hold     <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (capture) begin
                hold.coreid <= in_coreid;
                hold.csr    <= in_csr;
                hdr_drop    <= drop_cnt;
            end
            if (seq_inc) seq <= seq + 16'd1;
            if (in_valid && !in_ready) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign dropped = drop_cnt;

endmodule
